instr_fetch_ctrl: RTL and testbench

//   Sequences the 32-bit combinational instruction ROM (byte addresses, word-aligned, MEM_SIZE bytes).

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instr_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding and prefetch entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {F_IDLE, F_RUN, F_FAULT} fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it and dominates push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the ROM, buffers {pc, instr} for decode,
// handles redirects and stops with a sticky fault on illegal fetch addresses.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          MEM_SIZE = 1024,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam logic [63:0] LAST_PC = 64'(MEM_SIZE - INSTR_BYTES);

  // Compared as a <= MEM_SIZE-4 so that a+3 can never wrap at 64 bits.
  function automatic logic addr_legal(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_PC);
  endfunction

  fetch_state_t                state;
  fetch_state_t                next_state;
  logic [63:0]                 fetch_pc;
  logic                        pc_legal;
  logic                        redir_legal;
  logic                        push;
  logic                        pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(DEPTH):0]      fifo_level_unused;
  fetch_entry_t                head;
  fetch_entry_t                tail;

  assign pc_legal    = addr_legal(fetch_pc);
  assign redir_legal = addr_legal(redirect_pc);
  assign pop         = dec_valid && dec_ready;
  assign push        = (state == F_RUN) && fetch_en && pc_legal && !redirect &&
                       (!fifo_full || pop);
  assign tail        = '{pc: fetch_pc, instr: imem_instr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= F_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (redirect) begin
      if (!redir_legal)  next_state = F_FAULT;
      else if (fetch_en) next_state = F_RUN;
      else               next_state = F_IDLE;
    end else begin
      case (state)
        F_IDLE:  if (fetch_en) next_state = F_RUN;
        F_RUN: begin
          if (!pc_legal)      next_state = F_FAULT;
          else if (!fetch_en) next_state = F_IDLE;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      fault_pc <= '0;
    end else begin
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
      if (redirect && !redir_legal)
        fault_pc <= redirect_pc;
      else if (!redirect && (state == F_RUN) && !pc_legal)
        fault_pc <= fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata   (tail),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level_unused)
  );

  assign imem_addr = fetch_pc;
  assign fault     = (state == F_FAULT);
  assign dec_valid = !fifo_empty;
  assign dec_instr = dec_valid ? head.instr : '0;
  assign dec_pc    = dec_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: expected pc stream held in a scoreboard queue,
// popped and compared on every accepted decode handshake.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        fault;
  logic [63:0] fault_pc;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfer   = 0;
  int          x0;
  int          cyc;
  logic [63:0] exp_q [$];

  instr_fetch_ctrl #(
    .MEM_SIZE (1024),
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  function automatic logic [31:0] rom(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_instr = rom(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_seq(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    fetch_en = 1'b0;
    dec_ready = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    tick(1);
    reset_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [63:0] pc, input logic en);
    redirect    = 1'b1;
    redirect_pc = pc;
    fetch_en    = en;
    tick(1);
    redirect = 1'b0;
    exp_q.delete();
  endtask

  // Handshake monitor: inputs settle 1 time unit after posedge, so the negedge sees the
  // values that the following posedge will act on.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n && dec_valid && dec_ready) begin
      n_xfer++;
      chk("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_pc", dec_pc, e);
        chk("xfer_instr", 64'(dec_instr), 64'(rom(e)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; fetch_en = 1'b0; dec_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_dec_pc",    dec_pc,         64'd0);
    chk("rst_imem_addr", imem_addr,      64'd0);
    chk("rst_fault",     64'(fault),     64'd0);
    chk("rst_fault_pc",  fault_pc,       64'd0);

    // 1: first fetch latency and sequential delivery
    tick(1);
    reset_n = 1'b1; fetch_en = 1'b1; dec_ready = 1'b1;
    expect_seq(64'h0, 8);
    tick(1);
    chk("t1_valid_edge1", 64'(dec_valid), 64'd0);
    tick(1);
    chk("t1_valid_edge2", 64'(dec_valid), 64'd1);
    chk("t1_pc0", dec_pc, 64'h0);
    chk("t1_instr0", 64'(dec_instr), 64'(rom(64'h0)));
    tick(1);
    chk("t1_pc1", dec_pc, 64'h4);
    tick(1);
    chk("t1_pc2", dec_pc, 64'h8);
    chk("t1_instr2", 64'(dec_instr), 64'(rom(64'h8)));

    // 2: back-pressure fills the FIFO, then drains with no gap
    do_reset();
    fetch_en = 1'b1;
    tick(10);
    chk("t2_addr_hold", imem_addr, 64'd16);
    chk("t2_valid", 64'(dec_valid), 64'd1);
    chk("t2_head", dec_pc, 64'h0);
    expect_seq(64'h0, 12);
    x0 = n_xfer;
    dec_ready = 1'b1;
    tick(8);
    chk("t2_throughput", 64'(n_xfer - x0), 64'd8);
    chk("t2_head_after", dec_pc, 64'd32);

    // 3: redirect flushes three buffered entries
    do_reset();
    fetch_en = 1'b1;
    tick(4);
    chk("t3_addr_pre", imem_addr, 64'd12);
    do_redirect(64'h40, 1'b1);
    chk("t3_flush_valid", 64'(dec_valid), 64'd0);
    chk("t3_redir_addr", imem_addr, 64'h40);
    expect_seq(64'h40, 8);
    dec_ready = 1'b1;
    tick(1);
    chk("t3_valid", 64'(dec_valid), 64'd1);
    chk("t3_pc", dec_pc, 64'h40);
    tick(4);

    // 4: run off the end of the ROM
    do_redirect(64'd1000, 1'b1);
    expect_seq(64'd1000, 6);
    cyc = 0;
    while (!fault && cyc < 30) begin tick(1); cyc++; end
    chk("t4_fault", 64'(fault), 64'd1);
    chk("t4_fault_pc", fault_pc, 64'd1024);
    cyc = 0;
    while (dec_valid && cyc < 30) begin tick(1); cyc++; end
    chk("t4_drained", 64'(dec_valid), 64'd0);
    chk("t4_all_delivered", 64'(exp_q.size()), 64'd0);
    chk("t4_addr_hold", imem_addr, 64'd1024);
    do_redirect(64'h0, 1'b1);
    chk("t4_fault_clr", 64'(fault), 64'd0);
    expect_seq(64'h0, 8);
    tick(3);
    chk("t4_restart_head", dec_pc, 64'h8);

    // 5: misaligned redirect
    do_redirect(64'h6, 1'b1);
    chk("t5_fault", 64'(fault), 64'd1);
    chk("t5_fault_pc", fault_pc, 64'h6);
    chk("t5_valid", 64'(dec_valid), 64'd0);
    x0 = n_xfer;
    tick(2);
    fetch_en = 1'b0;
    tick(1);
    fetch_en = 1'b1;
    tick(2);
    chk("t5_no_push", 64'(n_xfer - x0), 64'd0);
    chk("t5_sticky", 64'(fault), 64'd1);
    chk("t5_addr", imem_addr, 64'h6);
    do_redirect(64'h100, 1'b1);
    chk("t5_fault_clr", 64'(fault), 64'd0);
    expect_seq(64'h100, 4);
    dec_ready = 1'b0;

    // 6: asynchronous reset with FIFO full, then fetch_en drop
    tick(6);
    chk("t6_full_addr", imem_addr, 64'h110);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(dec_valid), 64'd0);
    chk("t6_async_addr",  imem_addr,      64'h0);
    chk("t6_async_pc",    dec_pc,         64'h0);
    chk("t6_async_instr", 64'(dec_instr), 64'd0);
    exp_q.delete();
    fetch_en = 1'b0;
    tick(1);
    reset_n = 1'b1;
    fetch_en = 1'b1;
    expect_seq(64'h0, 2);
    tick(3);
    chk("t6_addr_run", imem_addr, 64'h8);
    fetch_en = 1'b0;
    tick(1);
    chk("t6_addr_stop", imem_addr, 64'h8);
    dec_ready = 1'b1;
    tick(5);
    chk("t6_addr_idle", imem_addr, 64'h8);
    chk("t6_drained", 64'(dec_valid), 64'd0);
    chk("t6_all_delivered", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
